// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types for the RV32I pipeline memory stage.
//   exmem_t     - EX/MEM bundle consumed by mem_stage
//   memwb_t     - MEM/WB bundle produced by mem_stage
//   F3_*        - funct3 encodings for loads and stores
//   RES_*       - ResultSrc encodings used by writeback
//   mem_state_e - memory-stage transaction FSM states
//   is_misaligned - alignment rule for a given access width
package pipeline_pkg;

    localparam int DATA_W = 32;

    // Loads use all five codes; stores use only F3_B/F3_H/F3_W.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } mem_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] ALUResult;
        logic [DATA_W-1:0] WriteData;
        logic [4:0]        Rd;
        logic              RegWrite;
        logic              MemRead;
        logic              MemWrite;
        logic [2:0]        funct3;
        logic [1:0]        ResultSrc;
        logic [DATA_W-1:0] PCPlus4;
        logic [DATA_W-1:0] ImmExt;
    } exmem_t;

    typedef struct packed {
        logic [DATA_W-1:0] ALUResult;
        logic [DATA_W-1:0] load_data;
        logic [DATA_W-1:0] PCPlus4;
        logic [DATA_W-1:0] ImmExt;
        logic [1:0]        ResultSrc;
        logic [4:0]        Rd;
        logic              RegWrite;
    } memwb_t;

    // Width is carried in funct3[1:0] for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis_s;
        case (funct3[1:0])
            2'b01:   mis_s = addr_lo[0];
            2'b10:   mis_s = (addr_lo != 2'b00);
            default: mis_s = 1'b0;
        endcase
        return mis_s;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load-data extractor.
//   rdata     in  32  raw word returned by memory
//   addr_lo   in  2   byte offset of the access
//   funct3    in  3   load type (LB/LH/LW/LBU/LHU)
//   load_data out 32  extracted, sign/zero-extended value
module load_align
    import pipeline_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte/half, then extend according to load type
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        load_data = 32'h0000_0000;
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'h00_0000, byte_s};
            F3_HU:   load_data = {16'h0000, half_s};
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage with MEM/WB pipeline register.
//   clk, rst_n          pipeline clock, async active-low reset
//   inputs              EX/MEM bundle (held stable by the hazard unit while StallM=1)
//   dmem_req/gnt        request handshake; req stays up until gnt
//   dmem_we/addr/wdata/wstrb  request fields (word address, lane-replicated data)
//   dmem_rvalid/rdata   response (load word or store ack)
//   StallM              freeze upstream stages while a transaction is open
//   MisalignM           one-cycle flag for a misaligned access (no request issued)
//   outputs             registered MEM/WB bundle
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32  // only 32 is supported
) (
    input  logic            clk,
    input  logic            rst_n,
    input  exmem_t          inputs,
    output logic            dmem_req,
    input  logic            dmem_gnt,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            StallM,
    output logic            MisalignM,
    output memwb_t          outputs
);

    mem_state_e  state_r;
    logic        mem_op_s;
    logic        mis_s;
    logic        start_s;
    logic        done_s;
    logic        req_s;
    logic        stall_s;
    logic [31:0] ld_data_s;
    logic [3:0]  strb_s;
    logic [31:0] wdata_s;
    memwb_t      wb_next_s;
    memwb_t      wb_r;

    assign mem_op_s = inputs.MemRead | inputs.MemWrite;
    assign mis_s    = mem_op_s & is_misaligned(inputs.funct3, inputs.ALUResult[1:0]);
    assign start_s  = (state_r == ST_IDLE) & mem_op_s & ~mis_s;
    assign done_s   = (state_r == ST_WAIT) & dmem_rvalid;
    assign req_s    = start_s | (state_r == ST_REQ);
    // The completing WAIT cycle is not a stall: upstream advances as MEM/WB captures.
    assign stall_s  = (start_s | (state_r != ST_IDLE)) & ~done_s;

    assign dmem_req   = req_s;
    assign dmem_we    = req_s & inputs.MemWrite;
    assign dmem_addr  = {inputs.ALUResult[31:2], 2'b00};
    assign dmem_wstrb = strb_s;
    assign dmem_wdata = wdata_s;
    assign StallM     = stall_s;
    assign MisalignM  = (state_r == ST_IDLE) & mis_s;
    assign outputs    = wb_r;

    load_align u_load_align (
        .rdata     (dmem_rdata),
        .addr_lo   (inputs.ALUResult[1:0]),
        .funct3    (inputs.funct3),
        .load_data (ld_data_s)
    );

    // Store lane steering; strobes and data are only driven for a live store request
    always_comb begin
        strb_s  = 4'b0000;
        wdata_s = 32'h0000_0000;
        if (req_s && inputs.MemWrite) begin
            case (inputs.funct3[1:0])
                2'b00: begin
                    strb_s  = 4'b0001 << inputs.ALUResult[1:0];
                    wdata_s = {4{inputs.WriteData[7:0]}};
                end
                2'b01: begin
                    strb_s  = 4'b0011 << inputs.ALUResult[1:0];
                    wdata_s = {2{inputs.WriteData[15:0]}};
                end
                default: begin
                    strb_s  = 4'b1111;
                    wdata_s = inputs.WriteData;
                end
            endcase
        end else begin
            strb_s  = 4'b0000;
            wdata_s = 32'h0000_0000;
        end
    end

    // Transaction FSM; a response outside WAIT is never consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r <= dmem_gnt ? ST_WAIT : ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Next MEM/WB contents: bubble while stalled, otherwise the bundle for this instruction
    always_comb begin
        wb_next_s = '0;
        if (stall_s) begin
            wb_next_s = '0;
        end else begin
            wb_next_s.ALUResult = inputs.ALUResult;
            wb_next_s.PCPlus4   = inputs.PCPlus4;
            wb_next_s.ImmExt    = inputs.ImmExt;
            wb_next_s.ResultSrc = inputs.ResultSrc;
            wb_next_s.Rd        = inputs.Rd;
            if (done_s) begin
                wb_next_s.RegWrite  = inputs.RegWrite;
                wb_next_s.load_data = inputs.MemRead ? ld_data_s : 32'h0000_0000;
            end else if (mis_s) begin
                wb_next_s.RegWrite  = 1'b0;
                wb_next_s.load_data = 32'h0000_0000;
            end else begin
                wb_next_s.RegWrite  = inputs.RegWrite;
                wb_next_s.load_data = 32'h0000_0000;
            end
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_r <= '0;
        end else begin
            wb_r <= wb_next_s;
        end
    end

endmodule
